// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge event unit.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_ANY  = 2'b11
  } edge_mode_e;

  // A one-channel build still needs a one-bit select port.
  function automatic int sel_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel of the edge event unit: synchroniser, edge qualification,
// registered pulse, sticky pending flag and saturating event counter.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             warm_done,
  input  edge_mode_e       mode,
  input  logic             clr,
  input  logic             cnt_clr_hit,
  output logic             edge_pulse,
  output logic             pending,
  output logic             pending_nxt,
  output logic [CNT_W-1:0] cnt
);

  logic s;
  logic prev;
  logic rise;
  logic fall;
  logic qualified;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edges are suppressed until the warm-up window has flushed the reset-state zeros.
  always_comb begin
    rise      = s & ~prev;
    fall      = ~s & prev;
    qualified = 1'b0;
    if (warm_done) begin
      case (mode)
        EDGE_RISE: qualified = rise;
        EDGE_FALL: qualified = fall;
        EDGE_ANY:  qualified = rise | fall;
        default:   qualified = 1'b0;
      endcase
    end
  end

  // A new pulse outranks a same-cycle clear so no event is ever dropped.
  assign pending_nxt = (pending & ~clr) | edge_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= 1'b0;
      edge_pulse <= 1'b0;
      pending    <= 1'b0;
      cnt        <= '0;
    end else begin
      prev       <= s;
      edge_pulse <= qualified;
      pending    <= pending_nxt;
      if (cnt_clr_hit) begin
        cnt <= edge_pulse ? CNT_W'(1) : '0;
      end else if (edge_pulse && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit: per-channel mode, sticky pending flags,
// saturating counters with a selectable readback and an aggregate interrupt.
module edge_event_unit
  import edge_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 8,
  localparam int SEL_W       = sel_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [2*WIDTH-1:0]   mode,
  output logic [WIDTH-1:0]     edge_pulse,
  output logic [WIDTH-1:0]     pending,
  input  logic [WIDTH-1:0]     clr_pending,
  input  logic [SEL_W-1:0]     cnt_sel,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_val,
  output logic                 irq
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(SYNC_STAGES + 1);

  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;
  logic [WIDTH-1:0]  pending_nxt;
  logic [WIDTH-1:0]  cnt_clr_hit;
  logic [CNT_W-1:0]  cnt_arr [WIDTH];

  // Warm-up counter stops once reached and only reset can re-arm it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  assign warm_done = (warm_cnt == WARM_END);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      assign cnt_clr_hit[i] = cnt_clr && (cnt_sel == SEL_W'(i));

      edge_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
      ) u_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (in[i]),
        .warm_done   (warm_done),
        .mode        (edge_mode_e'(mode[2*i +: 2])),
        .clr         (clr_pending[i]),
        .cnt_clr_hit (cnt_clr_hit[i]),
        .edge_pulse  (edge_pulse[i]),
        .pending     (pending[i]),
        .pending_nxt (pending_nxt[i]),
        .cnt         (cnt_arr[i])
      );
    end
  endgenerate

  // Out-of-range selects read as zero.
  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_sel == SEL_W'(i)) begin
        cnt_val = cnt_arr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |pending_nxt;
    end
  end

endmodule
